output_memory_node_strided: RTL

- Parametrised successor to the CGRA output memory node: buffers a 32-bit output stream from the CGRA and writes it to memory through an OBI master port.
- Adds a configurable FIFO depth, a signed byte stride between consecutive writes, and tracking of outstanding OBI transactions.
- done_o is raised only after every issued write has been acknowledged with rvalid.
- Sits between a CGRA output port and the system bus, one instance per output channel.

---
 rtl/output_memory_node_strided.sv | 116 +++++++++++
 1 files changed

// File: rtl/output_memory_node_strided.sv
// Strided CGRA output memory node: buffers a 32-bit stream in a FIFO and writes it out over OBI,
// advancing the address by a signed stride per grant and waiting for every rvalid before done.
module output_memory_node_strided #(
    parameter int unsigned FIFO_DEPTH      = 8,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned SIZE_W          = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    // {req, we, be[3:0], addr[31:0], wdata[31:0]}
    output logic [69:0]       masters_req_o,
    // {gnt, rvalid}
    input  logic [1:0]        masters_resp_i,
    input  logic [31:0]       omn_addr_i,
    input  logic [SIZE_W-1:0] omn_size_i,
    input  logic [15:0]       omn_stride_i,
    input  logic              exec_i,
    output logic              done_o,
    input  logic [31:0]       din_i,
    input  logic              din_v_i,
    output logic              din_r_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    state_e              state_q, state_d;
    logic [31:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [PTR_W:0]      count;
    logic [SIZE_W-1:0]   issued_q, n_words;
    logic [OUT_W-1:0]    outs_q;
    logic [31:0]         offset_q, stride_ext;
    logic                full, empty, push, pop, req, grant, gnt, rvalid;

    assign gnt        = masters_resp_i[1];
    assign rvalid     = masters_resp_i[0];
    assign n_words    = omn_size_i >> 2;
    assign stride_ext = {{16{omn_stride_i[15]}}, omn_stride_i};

    // din_r_o follows the registered count, so a pop while full does not reopen it this cycle
    assign full    = (count == (PTR_W + 1)'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign din_r_o = ~full;
    assign push    = din_v_i & ~full;
    assign grant   = req & gnt;
    assign pop     = grant;

    assign req = (state_q == RUN) && !empty && (issued_q < n_words)
              && (outs_q < OUT_W'(MAX_OUTSTANDING));

    assign masters_req_o = {req, 1'b1, 4'b1111, omn_addr_i + offset_q, mem[rd_ptr]};
    assign done_o        = (state_q == DONE);

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= din_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            issued_q <= '0;
            offset_q <= '0;
            outs_q   <= '0;
        end else if (clr_i) begin
            state_q  <= IDLE;
            issued_q <= '0;
            offset_q <= '0;
            outs_q   <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                issued_q <= issued_q + SIZE_W'(1);
                offset_q <= offset_q + stride_ext;
            end
            // stray rvalids (e.g. after a clear) must not wrap the counter below zero
            if (grant && !rvalid)
                outs_q <= outs_q + OUT_W'(1);
            else if (!grant && rvalid && outs_q != '0)
                outs_q <= outs_q - OUT_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (exec_i) state_d = (n_words == '0) ? DONE : RUN;
            RUN:     if (grant && (issued_q + SIZE_W'(1) == n_words)) state_d = DRAIN;
            DRAIN:   if (outs_q == '0 || (outs_q == OUT_W'(1) && rvalid)) state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end
endmodule
